// File: rtl/axis_row_split_pkg.sv
// rtl/axis_row_split_pkg.sv - shared constants for the row splitter
//
// Purpose: default row-counter width, stream data width and the parity
//          encoding used to pick the destination output of a row.
// Ports:   none (package).
package axis_row_split_pkg;

    // Default width of the row counter / row_idx output.
    localparam int LINE_CNT_W_DEF = 12;

    // Width of the pixel data carried by the Axis stream.
    localparam int AXIS_DATA_W = 16;

    // Row parity encoding: even rows leave on out0, odd rows on out1.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/Axis.sv
// rtl/Axis.sv - pixel stream interface with start-of-frame / end-of-line markers
//
// Purpose: carries one pixel per beat with valid/ready handshake.
// Signals: data  - pixel payload
//          sof   - first beat of a frame
//          eol   - last beat of a row
//          valid - source holds a beat
//          ready - sink accepts the beat this cycle
interface Axis;
    import axis_row_split_pkg::*;

    logic [AXIS_DATA_W-1:0] data;
    logic                   sof;
    logic                   eol;
    logic                   valid;
    logic                   ready;

    modport Master (output data, output sof, output eol, output valid, input ready);
    modport Slave  (input data, input sof, input eol, input valid, output ready);

endinterface

// File: rtl/axis_row_split.sv
// rtl/axis_row_split.sv - route alternate rows of a pixel stream to two outputs
//
// Purpose: even rows (0, 2, 4, ...) go to out0, odd rows to out1, through a
//          single registered output slot (1-cycle latency, full throughput).
// Ports:   clk      - clock, rising edge
//          rst      - asynchronous active-high reset
//          in       - input stream (Axis.Slave)
//          out0     - even-row output stream (Axis.Master)
//          out1     - odd-row output stream (Axis.Master)
//          row_idx  - row index of the beat held in the output slot
//          sof_err  - sticky: sof accepted while a row was still open
//          clr_err  - synchronous clear of sof_err (set wins)
module axis_row_split
    import axis_row_split_pkg::*;
#(
    parameter int LINE_CNT_W = LINE_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    Axis.Slave                    in,
    Axis.Master                   out0,
    Axis.Master                   out1,
    output logic [LINE_CNT_W-1:0] row_idx,
    output logic                  sof_err,
    input  logic                  clr_err
);

    // Output slot
    logic                   r_slot_valid;
    logic                   r_dest;
    logic [AXIS_DATA_W-1:0] r_data;
    logic                   r_sof;
    logic                   r_eol;
    logic [LINE_CNT_W-1:0]  r_row_idx;

    // Row tracking for the next accepted beat
    logic                   r_parity;
    logic                   r_row_open;
    logic [LINE_CNT_W-1:0]  r_row_cnt;
    logic                   r_sof_err;

    logic                   w_sel_ready;
    logic                   w_in_ready;
    logic                   w_acc;
    logic                   w_beat_par;
    logic [LINE_CNT_W-1:0]  w_beat_row;
    logic [LINE_CNT_W-1:0]  w_row_next;

    always_comb begin
        w_sel_ready = (r_dest == PAR_ODD) ? out1.ready : out0.ready;
        // The slot can take a new beat when empty or when it drains this cycle.
        w_in_ready  = ~r_slot_valid | w_sel_ready;
        w_acc       = in.valid & w_in_ready;
        // sof restarts the frame: the beat belongs to row 0 regardless of history.
        w_beat_par  = in.sof ? PAR_EVEN : r_parity;
        w_beat_row  = in.sof ? '0 : r_row_cnt;
        // Row counter saturates; parity keeps toggling independently.
        w_row_next  = (&w_beat_row) ? w_beat_row : w_beat_row + LINE_CNT_W'(1);
    end

    assign in.ready   = w_in_ready;
    assign out0.valid = r_slot_valid & (r_dest == PAR_EVEN);
    assign out1.valid = r_slot_valid & (r_dest == PAR_ODD);
    assign out0.data  = r_data;
    assign out1.data  = r_data;
    assign out0.sof   = r_sof;
    assign out1.sof   = r_sof;
    assign out0.eol   = r_eol;
    assign out1.eol   = r_eol;
    assign row_idx    = r_row_idx;
    assign sof_err    = r_sof_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_valid <= 1'b0;
            r_dest       <= PAR_EVEN;
            r_data       <= '0;
            r_sof        <= 1'b0;
            r_eol        <= 1'b0;
            r_row_idx    <= '0;
            r_parity     <= PAR_EVEN;
            r_row_open   <= 1'b0;
            r_row_cnt    <= '0;
            r_sof_err    <= 1'b0;
        end else begin
            if (w_acc) begin
                // Push (possibly simultaneous with a pop of the previous beat).
                r_slot_valid <= 1'b1;
                r_dest       <= w_beat_par;
                r_data       <= in.data;
                r_sof        <= in.sof;
                r_eol        <= in.eol;
                r_row_idx    <= w_beat_row;
                if (in.eol) begin
                    r_row_open <= 1'b0;
                    r_parity   <= ~w_beat_par;
                    r_row_cnt  <= w_row_next;
                end else begin
                    r_row_open <= 1'b1;
                    r_parity   <= w_beat_par;
                    r_row_cnt  <= w_beat_row;
                end
            end else if (w_sel_ready) begin
                r_slot_valid <= 1'b0;
            end

            if (w_acc && in.sof && r_row_open) begin
                r_sof_err <= 1'b1;
            end else if (clr_err) begin
                r_sof_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_row_split.sv
// tb/tb_axis_row_split.sv - self-checking bench for axis_row_split
module tb_axis_row_split;
    import axis_row_split_pkg::*;

    localparam int SAT_W   = 2;
    localparam int SAT_MAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr_err = 1'b0;

    always #5 clk = ~clk;

    Axis u_in ();
    Axis u_o0 ();
    Axis u_o1 ();
    Axis u_in_b ();
    Axis u_o0_b ();
    Axis u_o1_b ();

    logic [LINE_CNT_W_DEF-1:0] row_idx_a;
    logic [SAT_W-1:0]          row_idx_b;
    logic                      err_a;
    logic                      err_b;

    // Second instance with a 2-bit counter sees the identical stream.
    assign u_in_b.data  = u_in.data;
    assign u_in_b.sof   = u_in.sof;
    assign u_in_b.eol   = u_in.eol;
    assign u_in_b.valid = u_in.valid;
    assign u_o0_b.ready = u_o0.ready;
    assign u_o1_b.ready = u_o1.ready;

    axis_row_split u_dut (
        .clk     (clk),
        .rst     (rst),
        .in      (u_in),
        .out0    (u_o0),
        .out1    (u_o1),
        .row_idx (row_idx_a),
        .sof_err (err_a),
        .clr_err (clr_err)
    );

    axis_row_split #(.LINE_CNT_W(SAT_W)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .in      (u_in_b),
        .out0    (u_o0_b),
        .out1    (u_o1_b),
        .row_idx (row_idx_b),
        .sof_err (err_b),
        .clr_err (clr_err)
    );

    typedef struct {
        logic [AXIS_DATA_W-1:0] data;
        bit                     sof;
        bit                     eol;
    } beat_t;

    typedef struct {
        logic [AXIS_DATA_W-1:0] data;
        bit                     sof;
        bit                     eol;
        bit                     dest;
        int                     row;
    } exp_t;

    beat_t beat_q[$];
    exp_t  mq[$];
    int    log0[$];
    int    log1[$];
    int    logb[$];
    int    ex[$];

    int    checks = 0;
    int    errors = 0;
    int    stalls = 0;
    int    p_valid = 100;
    int    p0 = 100;
    int    p1 = 100;
    int    clr_mode = 0;

    // Model state: frame position in plain integer terms.
    int    m_row = 0;
    bit    m_open = 0;
    bit    m_err = 0;

    bit    acc_seen = 0;
    bit    have = 0;
    beat_t cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_log(input string name, input int got[$], input int want[$]);
        chk({name, "_len"}, 64'(got.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < got.size(); i++)
            chk($sformatf("%s_%0d", name, i), 64'(got[i]), 64'(want[i]));
    endtask

    // Source driver: holds each beat until accepted.
    initial begin
        u_in.valid = 1'b0;
        u_in.data  = '0;
        u_in.sof   = 1'b0;
        u_in.eol   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                have = 0;
            end else begin
                if (have && acc_seen) have = 0;
                if (!have && beat_q.size() > 0 && $urandom_range(0, 99) < p_valid) begin
                    cur  = beat_q.pop_front();
                    have = 1;
                end
            end
            u_in.valid = have;
            if (have) begin
                u_in.data = cur.data;
                u_in.sof  = cur.sof;
                u_in.eol  = cur.eol;
            end
        end
    end

    // Sinks
    initial begin
        u_o0.ready = 1'b1;
        u_o1.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            u_o0.ready = ($urandom_range(0, 99) < p0);
            u_o1.ready = ($urandom_range(0, 99) < p1);
            clr_err    = (clr_mode == 1) || (clr_mode == 2 && $urandom_range(0, 9) == 0);
        end
    end

    // Compare process: checks outputs against the model, then advances it
    // to the state it must hold after the coming rising edge.
    bit   c_ne;
    bit   c_er;
    bit   c_take;
    bit   c_acc;
    bit   c_set;
    exp_t c_h;
    exp_t c_n;

    always @(negedge clk) begin
        acc_seen = u_in.valid && u_in.ready && !rst;
        if (rst) begin
            mq.delete();
            m_row  = 0;
            m_open = 0;
            m_err  = 0;
        end else begin
            c_ne = (mq.size() > 0);
            if (c_ne) c_h = mq[0];
            c_er = !c_ne || (c_h.dest ? u_o1.ready : u_o0.ready);
            chk("in_ready", u_in.ready, c_er);
            chk("in_ready_b", u_in_b.ready, c_er);
            chk("out0_valid", u_o0.valid, c_ne && !c_h.dest);
            chk("out1_valid", u_o1.valid, c_ne && c_h.dest);
            chk("out0_valid_b", u_o0_b.valid, c_ne && !c_h.dest);
            chk("out1_valid_b", u_o1_b.valid, c_ne && c_h.dest);
            chk("sof_err", err_a, m_err);
            chk("sof_err_b", err_b, m_err);
            if (c_ne) begin
                chk("out0_data", u_o0.data, c_h.data);
                chk("out1_data", u_o1.data, c_h.data);
                chk("out_sof", c_h.dest ? u_o1.sof : u_o0.sof, c_h.sof);
                chk("out_eol", c_h.dest ? u_o1.eol : u_o0.eol, c_h.eol);
                chk("data_b", u_o0_b.data, c_h.data);
                chk("row_idx", row_idx_a, c_h.row);
                chk("row_idx_b", row_idx_b, (c_h.row > SAT_MAX) ? SAT_MAX : c_h.row);
            end
            if (u_in.valid && !u_in.ready) stalls++;

            c_take = c_ne && (c_h.dest ? u_o1.ready : u_o0.ready);
            c_acc  = u_in.valid && c_er;
            if (c_take) begin
                if (c_h.dest) log1.push_back(int'(row_idx_a));
                else          log0.push_back(int'(row_idx_a));
                logb.push_back(int'(row_idx_b));
                void'(mq.pop_front());
            end
            c_set = c_acc && u_in.sof && m_open;
            if (c_acc) begin
                if (u_in.sof) m_row = 0;
                c_n.data = u_in.data;
                c_n.sof  = u_in.sof;
                c_n.eol  = u_in.eol;
                c_n.row  = m_row;
                c_n.dest = (m_row % 2) == 1;
                mq.push_back(c_n);
                if (u_in.eol) begin
                    m_row++;
                    m_open = 0;
                end else begin
                    m_open = 1;
                end
            end
            if (c_set) m_err = 1;
            else if (clr_err) m_err = 0;
        end
    end

    task automatic push_beat(input bit sof, input bit eol);
        beat_t b;
        b.data = AXIS_DATA_W'($urandom);
        b.sof  = sof;
        b.eol  = eol;
        beat_q.push_back(b);
    endtask

    task automatic frame(input int rows, input int beats);
        for (int r = 0; r < rows; r++)
            for (int b = 0; b < beats; b++)
                push_beat(r == 0 && b == 0, b == beats - 1);
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        logb.delete();
    endtask

    task automatic drain(input string name, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #3;
            done = (beat_q.size() == 0) && !have && (mq.size() == 0);
        end
        chk({name, "_drain"}, done, 1);
    endtask

    task automatic wait_out1(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            found = u_o1.valid;
        end
        chk({name, "_wait_out1"}, found, 1);
    endtask

    logic [AXIS_DATA_W-1:0] held;

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out0_valid", u_o0.valid, 0);
        chk("rst_out1_valid", u_o1.valid, 0);
        chk("rst_row_idx", row_idx_a, 0);
        chk("rst_sof_err", err_a, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", u_in.ready, 1);

        // 4 rows x 3 beats, sinks always ready
        clear_logs();
        stalls = 0;
        frame(4, 3);
        drain("t_frame", 200);
        ex = '{0, 0, 0, 2, 2, 2};
        chk_log("t_frame_out0", log0, ex);
        ex = '{1, 1, 1, 3, 3, 3};
        chk_log("t_frame_out1", log1, ex);
        chk("t_frame_stalls", 64'(stalls), 0);

        // out1 back-pressured during row 1
        clear_logs();
        stalls = 0;
        p1 = 0;
        frame(4, 3);
        wait_out1("t_bp");
        held = u_o1.data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("t_bp_in_ready", u_in.ready, 0);
            chk("t_bp_hold", u_o1.data, held);
            chk("t_bp_row", row_idx_a, 1);
        end
        p1 = 100;
        drain("t_bp", 400);
        chk("t_bp_out0_cnt", 64'(log0.size()), 6);
        chk("t_bp_out1_cnt", 64'(log1.size()), 6);

        // sof at beat 2 of row 1
        clear_logs();
        push_beat(1, 0); push_beat(0, 0); push_beat(0, 1);
        push_beat(0, 0); push_beat(1, 0); push_beat(0, 1);
        push_beat(0, 1);
        drain("t_sof", 200);
        ex = '{0, 0, 0, 0, 0};
        chk_log("t_sof_out0", log0, ex);
        ex = '{1, 1};
        chk_log("t_sof_out1", log1, ex);
        chk("t_sof_err_set", err_a, 1);
        clr_mode = 1;
        repeat (2) @(posedge clk);
        clr_mode = 0;
        @(negedge clk);
        chk("t_sof_err_clr", err_a, 0);

        // set beats clear when both happen in the same cycle
        clr_mode = 1;
        push_beat(0, 0); push_beat(1, 1);
        drain("t_prio", 200);
        clr_mode = 0;

        // one-pixel rows, counter saturation on the 2-bit instance
        clear_logs();
        push_beat(1, 1);
        for (int i = 0; i < 5; i++) push_beat(0, 1);
        drain("t_pix", 200);
        ex = '{0, 2, 4};
        chk_log("t_pix_out0", log0, ex);
        ex = '{1, 3, 5};
        chk_log("t_pix_out1", log1, ex);
        ex = '{0, 1, 2, 3, 3, 3};
        chk_log("t_sat_b", logb, ex);

        // reset mid-row 1 with the slot full
        p1 = 0;
        frame(4, 3);
        wait_out1("t_rst");
        #2 rst = 1'b1;
        #1;
        chk("t_rst_out0_valid", u_o0.valid, 0);
        chk("t_rst_out1_valid", u_o1.valid, 0);
        chk("t_rst_row_idx", row_idx_a, 0);
        beat_q.delete();
        p1 = 100;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        clear_logs();
        push_beat(0, 1); push_beat(0, 1);
        drain("t_rst", 200);
        ex = '{0};
        chk_log("t_rst_out0", log0, ex);
        ex = '{1};
        chk_log("t_rst_out1", log1, ex);

        // randomized traffic
        p_valid  = 70;
        p0       = 60;
        p1       = 60;
        clr_mode = 2;
        for (int r = 0; r < 120; r++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++)
                push_beat((b == 0 && r % 6 == 0) || $urandom_range(0, 19) == 0, b == len - 1);
        end
        drain("t_rand", 5000);
        clr_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_row_split.md
AXIS_ROW_SPLIT -- requirements
Module: axis_row_split

Interface
REQ-001 SHALL have parameter LINE_CNT_W, default 12, width of the row counter output.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in, Axis.Slave, interface, input stream with data/sof/eol/valid/ready.
REQ-005 SHALL have port out0, Axis.Master, interface, even rows (row 0, 2, 4, ...).
REQ-006 SHALL have port out1, Axis.Master, interface, odd rows (row 1, 3, 5, ...).
REQ-007 SHALL have port row_idx, output, LINE_CNT_W, index of the row currently held in the output register.
REQ-008 SHALL have port sof_err, output, 1, sticky flag: sof was accepted while a row was open.
REQ-009 SHALL have port clr_err, input, 1, synchronous clear of sof_err.

Function
REQ-010 SHALL route each input row, delimited by eol, to exactly one of out0 or out1, alternating by row parity.
REQ-011 SHALL register data, sof and eol in a single output slot plus a dest bit: 1-cycle latency, in-order, no beat dropped or duplicated.
REQ-012 SHALL drive out0.valid = slot_valid & ~dest and out1.valid = slot_valid & dest; the non-selected output valid SHALL be 0.
REQ-013 SHALL present slot data/sof/eol on both outputs; only valid qualifies them.
REQ-014 SHALL drive in.ready = ~slot_valid | (dest ? out1.ready : out0.ready), giving full throughput when the selected sink is ready.
REQ-015 SHALL count an input beat as accepted when in.valid & in.ready, and an output beat as taken when the selected valid & ready.
REQ-016 SHALL load the slot on the same cycle as a take (simultaneous pop/push) without a bubble.
REQ-017 SHALL hold the slot contents stable while the selected output valid=1 and ready=0.
REQ-018 SHALL keep state parity (0 = even, 1 = odd) and state row_open (a row is in progress).
REQ-019 SHALL, on an accepted beat with sof=1: route the beat to out0, set row_idx to 0, and set parity to 0 for this row.
REQ-020 SHALL, on an accepted beat with eol=1: clear row_open, toggle parity, and increment the row counter for the next row.
REQ-021 SHALL, on an accepted beat without eol, set row_open.
REQ-022 SHALL, on an accepted beat with sof=1 and eol=1 (one-pixel row), apply REQ-019 and then REQ-020: the next row goes to out1 with row_idx 1.
REQ-023 SHALL saturate the row counter at 2^LINE_CNT_W-1; parity SHALL still toggle after saturation.
REQ-024 SHALL set sof_err when sof=1 is accepted while row_open=1, and then restart as in REQ-019.
REQ-025 SHALL have set priority over clr_err in the same cycle.
REQ-026 SHALL set row_idx to the row of the beat currently in the slot.

Reset
REQ-027 SHALL, on rst, clear slot_valid, dest, parity, row_open, row counter, row_idx and sof_err to 0 asynchronously; in.ready SHALL be 1 from the first cycle after release.
REQ-028 SHALL, when rst is asserted mid-row, discard the partial row; the first row after reset goes to out0.

Structure
REQ-029 SHALL take the Axis interface from the shared interface file; no new package types are required.
REQ-030 SHALL place LINE_CNT_W default and parity encoding constants (EVEN=0, ODD=1) in the shared reorder package.
REQ-031 SHALL be a single module with no sub-module; the output slot is inline.

Verification
REQ-032 SHALL cover: frame of 4 rows x 3 beats, sinks always ready -> rows 0 and 2 on out0, rows 1 and 3 on out1, row_idx 0..3, one beat per cycle.
REQ-033 SHALL cover: out1.ready=0 for 5 cycles during row 1 -> in.ready=0 while slot holds a row-1 beat; data stable; no loss after release.
REQ-034 SHALL cover: sof at beat 2 of row 1 -> sof_err=1, that beat on out0 with row_idx 0; clr_err then clears the flag.
REQ-035 SHALL cover: one-pixel rows (sof=eol=1, then eol-only beats) -> strict out0/out1 alternation.
REQ-036 SHALL cover: LINE_CNT_W=2, 6 rows -> row_idx 0,1,2,3,3,3 and parity alternation continues.
REQ-037 SHALL cover: rst asserted mid-row 1 with slot full -> all outputs 0 immediately; next row goes to out0.
